// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU operation codes and control FSM state encodings
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;
    // AOP_NONE is used by states that do not use the ALU, which drive ALUcontrol to 0
    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_NONE  = 2'b11
    } alu_op_t;
endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: instruction fields and zero flag in, datapath controls out
interface mc_control_if #(parameter int CNT_W = 32);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic zero;
    logic [3:0] ALUcontrol;
    logic RegWrite, MemtoReg, MemWrite, Branch;
    logic PCWrite, IRWrite, IorD, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic pc_en, illegal, retire;
    logic [CNT_W-1:0] instr_count;
    modport master (
        input opcode, funct, zero,
        output ALUcontrol, RegWrite, MemtoReg, MemWrite, Branch, PCWrite, IRWrite, IorD, RegDst,
        output ALUSrcA, ALUSrcB, PCSrc, pc_en, illegal, retire, instr_count
    );
    modport slave (
        output opcode, funct, zero,
        input ALUcontrol, RegWrite, MemtoReg, MemWrite, Branch, PCWrite, IRWrite, IorD, RegDst,
        input ALUSrcA, ALUSrcB, PCSrc, pc_en, illegal, retire, instr_count
    );
endinterface

// File: rtl/alu_decoder.sv
// alu_decoder: maps the FSM alu_op and the R-type funct field to a 4-bit ALU operation
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_control
);
    logic [3:0] fn_ctl;
    always_comb begin
        fn_ctl = ALU_ADD;
        case (funct)
            FN_SUB:  fn_ctl = ALU_SUB;
            FN_AND:  fn_ctl = ALU_AND;
            FN_OR:   fn_ctl = ALU_OR;
            FN_SLT:  fn_ctl = ALU_SLT;
            default: fn_ctl = ALU_ADD;
        endcase
    end
    assign alu_control = alu_op == AOP_ADD   ? ALU_ADD :
                         alu_op == AOP_SUB   ? ALU_SUB :
                         alu_op == AOP_FUNCT ? fn_ctl  : ALU_AND;
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main control FSM with embedded ALU decoder and retire counter
module mc_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input logic clk,
    input logic rst,
    mc_control_if.master bus
);
    state_t state;
    logic run;
    logic is_lw;
    logic [CNT_W-1:0] cnt;
    alu_op_t alu_op;
    logic legal, pc_write, branch, retire;
    assign legal = bus.opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    // run keeps every enable quiet for the first cycle after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            run   <= 1'b0;
            is_lw <= 1'b0;
            cnt   <= '0;
        end else begin
            run <= 1'b1;
            if (retire) cnt <= cnt + 1'b1;
            if (state == DECODE) is_lw <= bus.opcode == OP_LW;
            if (!run) state <= FETCH;
            else begin
                case (state)
                    FETCH:  state <= DECODE;
                    DECODE: begin
                        case (bus.opcode)
                            OP_LW, OP_SW: state <= MEMADR;
                            OP_RTYPE:     state <= EXEC;
                            OP_BEQ:       state <= BEQ;
                            OP_ADDI:      state <= ADDIEX;
                            OP_J:         state <= JUMP;
                            default:      state <= FETCH;
                        endcase
                    end
                    MEMADR:  state <= is_lw ? MEMRD : MEMWR;
                    MEMRD:   state <= MEMWB;
                    EXEC:    state <= ALUWB;
                    ADDIEX:  state <= ADDIWB;
                    default: state <= FETCH;
                endcase
            end
        end
    end
    assign pc_write = run && state inside {FETCH, JUMP};
    assign branch   = run && state == BEQ;
    assign retire   = run && state inside {MEMWB, MEMWR, ALUWB, ADDIWB, BEQ, JUMP};
    assign alu_op   = state inside {FETCH, DECODE, MEMADR, ADDIEX} ? AOP_ADD :
                      state == EXEC ? AOP_FUNCT :
                      state == BEQ  ? AOP_SUB : AOP_NONE;
    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (bus.funct),
        .alu_control (bus.ALUcontrol)
    );
    assign bus.PCWrite     = pc_write;
    assign bus.Branch      = branch;
    assign bus.retire      = retire;
    assign bus.IRWrite     = run && state == FETCH;
    assign bus.RegWrite    = run && state inside {MEMWB, ALUWB, ADDIWB};
    assign bus.MemWrite    = run && state == MEMWR;
    assign bus.MemtoReg    = state == MEMWB;
    assign bus.IorD        = state inside {MEMRD, MEMWR};
    assign bus.RegDst      = state == ALUWB;
    assign bus.ALUSrcA     = state inside {MEMADR, ADDIEX, EXEC, BEQ};
    assign bus.ALUSrcB     = state == FETCH ? 2'b01 : state inside {DECODE, MEMADR, ADDIEX} ? 2'b10 : 2'b00;
    assign bus.PCSrc       = state == BEQ ? 2'b01 : state == JUMP ? 2'b10 : 2'b00;
    assign bus.pc_en       = pc_write | (branch & bus.zero);
    assign bus.illegal     = run && state == DECODE && !legal;
    assign bus.instr_count = cnt;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed sequence through every instruction class, reset abort and counter wrap
module tb_mc_control;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    mc_control_if #(.CNT_W(32)) b1 ();
    mc_control_if #(.CNT_W(2))  b2 ();
    mc_control #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(b1));
    mc_control #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(b2));
    assign b2.opcode = b1.opcode;
    assign b2.funct  = b1.funct;
    assign b2.zero   = b1.zero;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [5:0] fns  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [3:0] alus [5] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    initial begin
        rst = 1'b1;
        b1.opcode = 6'b0;
        b1.funct = 6'b0;
        b1.zero = 1'b0;
        repeat (2) step();
        chk("rst_pcwrite", b1.PCWrite, 0);
        chk("rst_irwrite", b1.IRWrite, 0);
        chk("rst_aluctl", b1.ALUcontrol, 4'b0010);
        chk("rst_alusrcb", b1.ALUSrcB, 2'b01);
        chk("rst_count", b1.instr_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_irwrite", b1.IRWrite, 0);
        chk("post_rst_pcwrite", b1.PCWrite, 0);
        chk("post_rst_pc_en", b1.pc_en, 0);
        step();
        chk("fetch_irwrite", b1.IRWrite, 1);
        chk("fetch_pcwrite", b1.PCWrite, 1);
        chk("fetch_pc_en", b1.pc_en, 1);
        // lw: FETCH DECODE MEMADR MEMRD MEMWB
        b1.opcode = 6'b100011;
        step();
        chk("lw_dec_alusrcb", b1.ALUSrcB, 2'b10);
        chk("lw_dec_irwrite", b1.IRWrite, 0);
        step();
        chk("lw_adr_alusrca", b1.ALUSrcA, 1);
        chk("lw_adr_alusrcb", b1.ALUSrcB, 2'b10);
        step();
        chk("lw_rd_iord", b1.IorD, 1);
        chk("lw_rd_regwrite", b1.RegWrite, 0);
        step();
        chk("lw_wb_regwrite", b1.RegWrite, 1);
        chk("lw_wb_memtoreg", b1.MemtoReg, 1);
        chk("lw_wb_memwrite", b1.MemWrite, 0);
        chk("lw_wb_retire", b1.retire, 1);
        step();
        chk("lw_done_irwrite", b1.IRWrite, 1);
        chk("lw_done_count", b1.instr_count, 1);
        // sw: FETCH DECODE MEMADR MEMWR
        b1.opcode = 6'b101011;
        repeat (3) step();
        chk("sw_wr_memwrite", b1.MemWrite, 1);
        chk("sw_wr_iord", b1.IorD, 1);
        chk("sw_wr_memtoreg", b1.MemtoReg, 0);
        chk("sw_wr_regwrite", b1.RegWrite, 0);
        chk("sw_wr_retire", b1.retire, 1);
        step();
        chk("sw_done_irwrite", b1.IRWrite, 1);
        chk("sw_done_count", b1.instr_count, 2);
        // R-type funct sweep
        b1.opcode = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            b1.funct = fns[i];
            repeat (2) step();
            chk($sformatf("rt%0d_aluctl", i), b1.ALUcontrol, alus[i]);
            chk($sformatf("rt%0d_alusrcb", i), b1.ALUSrcB, 2'b00);
            step();
            chk($sformatf("rt%0d_regdst", i), b1.RegDst, 1);
            chk($sformatf("rt%0d_regwrite", i), b1.RegWrite, 1);
            chk($sformatf("rt%0d_illegal", i), b1.illegal, 0);
            step();
        end
        chk("rt_count", b1.instr_count, 7);
        // beq taken
        b1.opcode = 6'b000100;
        b1.zero = 1'b1;
        step();
        chk("beq_dec_pc_en", b1.pc_en, 0);
        step();
        chk("beq1_pc_en", b1.pc_en, 1);
        chk("beq1_pcwrite", b1.PCWrite, 0);
        chk("beq1_pcsrc", b1.PCSrc, 2'b01);
        chk("beq1_aluctl", b1.ALUcontrol, 4'b0110);
        chk("beq1_retire", b1.retire, 1);
        step();
        chk("beq1_fetch", b1.IRWrite, 1);
        // beq not taken
        b1.zero = 1'b0;
        repeat (2) step();
        chk("beq0_pc_en", b1.pc_en, 0);
        chk("beq0_branch", b1.Branch, 1);
        chk("beq0_retire", b1.retire, 1);
        step();
        chk("beq_count", b1.instr_count, 9);
        // addi
        b1.opcode = 6'b001000;
        repeat (2) step();
        chk("addi_ex_alusrcb", b1.ALUSrcB, 2'b10);
        chk("addi_ex_aluctl", b1.ALUcontrol, 4'b0010);
        step();
        chk("addi_wb_regwrite", b1.RegWrite, 1);
        chk("addi_wb_regdst", b1.RegDst, 0);
        chk("addi_wb_retire", b1.retire, 1);
        step();
        chk("addi_count", b1.instr_count, 10);
        // j
        b1.opcode = 6'b000010;
        repeat (2) step();
        chk("j_pcwrite", b1.PCWrite, 1);
        chk("j_pcsrc", b1.PCSrc, 2'b10);
        chk("j_retire", b1.retire, 1);
        step();
        chk("j_count", b1.instr_count, 11);
        // illegal opcode
        b1.opcode = 6'b111111;
        step();
        chk("ill_pulse", b1.illegal, 1);
        chk("ill_retire", b1.retire, 0);
        step();
        chk("ill_fetch", b1.IRWrite, 1);
        chk("ill_clear", b1.illegal, 0);
        chk("ill_count", b1.instr_count, 11);
        chk("wrap_pre", b2.instr_count, 3);
        // abort lw in MEMRD
        b1.opcode = 6'b100011;
        repeat (3) step();
        chk("abort_pre_iord", b1.IorD, 1);
        rst = 1'b1;
        #1;
        chk("abort_iord", b1.IorD, 0);
        chk("abort_irwrite", b1.IRWrite, 0);
        chk("abort_pcwrite", b1.PCWrite, 0);
        chk("abort_regwrite", b1.RegWrite, 0);
        chk("abort_retire", b1.retire, 0);
        chk("abort_count", b1.instr_count, 0);
        chk("abort_count2", b2.instr_count, 0);
        step();
        rst = 1'b0;
        step();
        // four jumps: CNT_W=2 counter wraps to 0
        b1.opcode = 6'b000010;
        repeat (3) repeat (3) step();
        chk("wrap3", b2.instr_count, 3);
        repeat (3) step();
        chk("wrap4", b2.instr_count, 0);
        chk("wrap4_wide", b1.instr_count, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
